// File: rtl/cdb_pkg.sv
// Shared types and helpers for the common-data-bus arbiter.
package cdb_pkg;

    localparam int DEF_TAG_W  = 4;
    localparam int DEF_DATA_W = 32;

    // Upper bound on source count handled by the round-robin helper.
    localparam int RR_MAX_FU = 32;

    // Tag value meaning "no producer"; never broadcast.
    localparam logic [DEF_TAG_W-1:0] NO_TAG = '0;

    typedef struct packed {
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_DATA_W-1:0] data;
    } cdb_msg_t;

    // Round-robin grant: scan req from ptr upward, wrap to 0, and grant
    // the first num_bus requesters found. Pass 0 covers i >= ptr, pass 1
    // covers the wrapped part i < ptr.
    function automatic logic [RR_MAX_FU-1:0] rr_grant(
        input logic [RR_MAX_FU-1:0] req,
        input int                   num_fu,
        input int                   num_bus,
        input int                   ptr
    );
        logic [RR_MAX_FU-1:0] gnt;
        int n;
        gnt = '0;
        n   = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < RR_MAX_FU; i++) begin
                if ((i < num_fu) && ((pass == 0) == (i >= ptr)) && req[i] && (n < num_bus)) begin
                    gnt[i] = 1'b1;
                    n++;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-source and broadcast-bus bundle of the CDB arbiter.
//
// Handshake: source i offers {fu_tag[i], fu_data[i]} with fu_valid[i];
// the entry is taken at the rising edge where fu_valid[i] & fu_ready[i].
// Offering while fu_ready[i] is low loses the entry and latches overflow[i].
// The broadcast side has no backpressure: cdb_valid[k] lasts one cycle and
// consumers must sample it on the next edge.
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int NUM_FU  = 2,
    parameter int NUM_BUS = 2,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int DATA_W  = DEF_DATA_W
);
    logic [NUM_FU-1:0]                fu_valid;
    logic [NUM_FU-1:0][TAG_W-1:0]     fu_tag;
    logic [NUM_FU-1:0][DATA_W-1:0]    fu_data;
    logic [NUM_FU-1:0]                fu_ready;
    logic [NUM_BUS-1:0]               cdb_valid;
    logic [NUM_BUS-1:0][TAG_W-1:0]    cdb_tag;
    logic [NUM_BUS-1:0][DATA_W-1:0]   cdb_data;
    logic [NUM_FU-1:0]                overflow;

    modport master (
        output fu_valid, fu_tag, fu_data,
        input  fu_ready, cdb_valid, cdb_tag, cdb_data, overflow
    );

    modport slave (
        input  fu_valid, fu_tag, fu_data,
        output fu_ready, cdb_valid, cdb_tag, cdb_data, overflow
    );

endinterface

// File: rtl/cdb_fifo.sv
// Per-source result FIFO; pointers wrap naturally, count has one extra bit.
module cdb_fifo
    import cdb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type msg_t = cdb_msg_t,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  msg_t          push_msg,
    input  logic          pop,
    output msg_t          head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    msg_t          mem_q [DEPTH];
    msg_t          mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign count = cnt_q;
    assign head  = mem_q[rd_q];

    // Next storage, pointers and occupancy; a full FIFO never accepts.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (do_push) begin
            mem_d[wr_q] = push_msg;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: NUM_FU result FIFOs, round-robin onto NUM_BUS buses.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU  = 2,
    parameter int NUM_BUS = 2,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = 4
) (
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.slave  io
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } msg_t;

    msg_t                          head [NUM_FU];
    logic [CNT_W-1:0]              count [NUM_FU];
    logic [NUM_FU-1:0]             empty, full, ready, push, grant;
    logic [RR_MAX_FU-1:0]          grant_full;
    int                            pos [NUM_FU];
    int                            scan_cnt, last_lo, last_any, last_idx;

    logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [NUM_BUS-1:0]            cdb_valid_q, cdb_valid_d;
    logic [NUM_BUS-1:0][TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [NUM_BUS-1:0][DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [NUM_FU-1:0]             overflow_q, overflow_d;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
        cdb_fifo #(
            .DEPTH (DEPTH),
            .msg_t (msg_t)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push[g]),
            .push_msg (msg_t'{tag: io.fu_tag[g], data: io.fu_data[g]}),
            .pop      (grant[g]),
            .head     (head[g]),
            .count    (count[g]),
            .empty    (empty[g]),
            .full     (full[g])
        );
    end

    // Ready from occupancy (not pop-aware); tag-0 pushes are dropped silently.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            ready[i] = (count[i] < CNT_W'(DEPTH));
            push[i]  = io.fu_valid[i] && ready[i] && (io.fu_tag[i] != TAG_W'(NO_TAG));
        end
        overflow_d = overflow_q | (io.fu_valid & full);
    end

    // Grant the first NUM_BUS non-empty FIFOs in scan order from rr_ptr.
    always_comb begin
        grant_full = rr_grant(RR_MAX_FU'(~empty), NUM_FU, NUM_BUS, int'(rr_ptr_q));
        grant      = grant_full[NUM_FU-1:0];
    end

    // Pointer follows the last grant in scan order: the highest granted index
    // below rr_ptr if the scan wrapped, otherwise the highest granted index.
    always_comb begin
        last_lo  = -1;
        last_any = -1;
        for (int i = 0; i < RR_MAX_FU; i++) begin
            if (grant_full[i]) begin
                last_any = i;
                if (i < int'(rr_ptr_q)) begin
                    last_lo = i;
                end
            end
        end
        last_idx = (last_lo >= 0) ? last_lo : last_any;
        rr_ptr_d = (last_idx >= 0) ? PTR_W'((last_idx + 1) % NUM_FU) : rr_ptr_q;
    end

    // The j-th grant in scan order drives bus j; unused buses stay zero.
    always_comb begin
        scan_cnt = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            pos[i] = 0;
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (((pass == 0) == (i >= int'(rr_ptr_q))) && grant[i]) begin
                    pos[i] = scan_cnt;
                    scan_cnt++;
                end
            end
        end
        cdb_valid_d = '0;
        cdb_tag_d   = '0;
        cdb_data_d  = '0;
        for (int b = 0; b < NUM_BUS; b++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (grant[i] && (pos[i] == b)) begin
                    cdb_valid_d[b] = 1'b1;
                    cdb_tag_d[b]   = head[i].tag;
                    cdb_data_d[b]  = head[i].data;
                end
            end
        end
    end

    // Arbitration pointer, broadcast registers and sticky overflow flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            overflow_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign io.fu_ready  = ready;
    assign io.cdb_valid = cdb_valid_q;
    assign io.cdb_tag   = cdb_tag_q;
    assign io.cdb_data  = cdb_data_q;
    assign io.overflow  = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a one-bus and a two-bus instance share stimulus and
// are compared every cycle against a queue-based reference model.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NF    = 2;
    localparam int TW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef logic [TW+DW-1:0] m_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NF-1:0]         vin;
    logic [NF-1:0][TW-1:0] tin;
    logic [NF-1:0][DW-1:0] din;

    cdb_arbiter_if #(.NUM_FU(NF), .NUM_BUS(1), .TAG_W(TW), .DATA_W(DW)) if1 ();
    cdb_arbiter_if #(.NUM_FU(NF), .NUM_BUS(2), .TAG_W(TW), .DATA_W(DW)) if2 ();

    assign if1.fu_valid = vin;
    assign if1.fu_tag   = tin;
    assign if1.fu_data  = din;
    assign if2.fu_valid = vin;
    assign if2.fu_tag   = tin;
    assign if2.fu_data  = din;

    cdb_arbiter #(.NUM_FU(NF), .NUM_BUS(1), .TAG_W(TW), .DATA_W(DW), .DEPTH(DEPTH))
        dut1 (.clk(clk), .reset(reset), .io(if1));
    cdb_arbiter #(.NUM_FU(NF), .NUM_BUS(2), .TAG_W(TW), .DATA_W(DW), .DEPTH(DEPTH))
        dut2 (.clk(clk), .reset(reset), .io(if2));

    // Reference model: instance s (bus count s+1) keeps one queue per source.
    m_t                     fq [2*NF][$];
    int                     ptr [2];
    logic [NF-1:0]          ovf [2];
    logic [1:0]             ev [2];
    logic [1:0][TW-1:0]     et [2];
    logic [1:0][DW-1:0]     ed [2];

    int total = 0;
    int bad   = 0;

    // Observation log of instance-0 broadcasts and valid activity.
    logic [TW-1:0] seen0 [$];
    int            valid_events;
    bit            ready0_low_seen;

    function automatic void model_reset();
        for (int q = 0; q < 2*NF; q++) fq[q].delete();
        for (int s = 0; s < 2; s++) begin
            ptr[s] = 0;
            ovf[s] = '0;
            ev[s]  = '0;
            et[s]  = '0;
            ed[s]  = '0;
        end
    endfunction

    function automatic logic [NF-1:0] rdy_exp(input int s);
        logic [NF-1:0] r;
        for (int f = 0; f < NF; f++) r[f] = (fq[s*NF+f].size() < DEPTH);
        return r;
    endfunction

    function automatic void model_edge();
        for (int s = 0; s < 2; s++) begin
            logic [NF-1:0] rdy;
            int n;
            int last;
            int f;
            m_t m;
            rdy   = rdy_exp(s);
            ev[s] = '0;
            et[s] = '0;
            ed[s] = '0;
            n     = 0;
            last  = -1;
            for (int k = 0; k < NF; k++) begin
                f = (ptr[s] + k) % NF;
                if (fq[s*NF+f].size() > 0 && n < s + 1) begin
                    m = fq[s*NF+f].pop_front();
                    ev[s][n] = 1'b1;
                    {et[s][n], ed[s][n]} = m;
                    n++;
                    last = f;
                end
            end
            if (last >= 0) ptr[s] = (last + 1) % NF;
            for (int g = 0; g < NF; g++) begin
                if (vin[g]) begin
                    if (rdy[g]) begin
                        if (tin[g] != '0) fq[s*NF+g].push_back({tin[g], din[g]});
                    end else begin
                        ovf[s][g] = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_all();
        check("i0_valid", 64'(if1.cdb_valid), 64'(ev[0][0]));
        check("i0_tag",   64'(if1.cdb_tag),   64'(et[0][0]));
        check("i0_data",  64'(if1.cdb_data),  64'(ed[0][0]));
        check("i0_ovf",   64'(if1.overflow),  64'(ovf[0]));
        check("i0_ready", 64'(if1.fu_ready),  64'(rdy_exp(0)));
        check("i1_valid", 64'(if2.cdb_valid), 64'(ev[1]));
        check("i1_tag",   64'(if2.cdb_tag),   64'(et[1]));
        check("i1_data",  64'(if2.cdb_data),  64'(ed[1]));
        check("i1_ovf",   64'(if2.overflow),  64'(ovf[1]));
        check("i1_ready", 64'(if2.fu_ready),  64'(rdy_exp(1)));
    endtask

    // One clock: advance the model at the edge, compare 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
        check_all();
        if (if1.cdb_valid[0] === 1'b1) seen0.push_back(if1.cdb_tag);
        if (if1.fu_ready[0] === 1'b0) ready0_low_seen = 1'b1;
        if ((|if1.cdb_valid) || (|if2.cdb_valid)) valid_events++;
    endtask

    task automatic drive(input logic [NF-1:0] v, input logic [TW-1:0] t0, input logic [DW-1:0] d0,
                         input logic [TW-1:0] t1, input logic [DW-1:0] d1);
        vin    = v;
        tin[0] = t0;
        din[0] = d0;
        tin[1] = t1;
        din[1] = d1;
    endtask

    task automatic idle(input int n);
        drive(2'b00, '0, '0, '0, '0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        seen0.delete();
        valid_events    = 0;
        ready0_low_seen = 1'b0;
    endtask

    initial begin
        model_reset();
        valid_events    = 0;
        ready0_low_seen = 1'b0;

        // Reset held two cycles with every source offering a result.
        reset = 1'b1;
        drive(2'b11, 4'd1, 32'h1, 4'd2, 32'h2);
        tick();
        tick();
        reset = 1'b0;
        idle(2);
        check("reset_nothing_queued", 64'(valid_events), 64'd0);

        // Single push: visible exactly one cycle after the push edge.
        do_reset();
        drive(2'b01, 4'd3, 32'h10, '0, '0);
        tick();
        check("single_not_early", 64'(if1.cdb_valid), 64'd0);
        idle(1);
        check("single_valid", 64'(if1.cdb_valid), 64'd1);
        check("single_tag",   64'(if1.cdb_tag),   64'd3);
        check("single_data",  64'(if1.cdb_data),  64'h10);
        idle(1);
        check("single_one_cycle", 64'(if1.cdb_valid), 64'd0);

        // Round-robin on the one-bus instance: order 1,5,2,6.
        do_reset();
        drive(2'b11, 4'd1, 32'h100, 4'd5, 32'h500);
        tick();
        drive(2'b11, 4'd2, 32'h200, 4'd6, 32'h600);
        tick();
        idle(5);
        check("rr_count", 64'(seen0.size()), 64'd4);
        if (seen0.size() == 4) begin
            check("rr_0", 64'(seen0[0]), 64'd1);
            check("rr_1", 64'(seen0[1]), 64'd5);
            check("rr_2", 64'(seen0[2]), 64'd2);
            check("rr_3", 64'(seen0[3]), 64'd6);
        end

        // Dual bus: both sources broadcast in the same cycle.
        do_reset();
        drive(2'b11, 4'd2, 32'hAA, 4'd7, 32'hBB);
        tick();
        idle(1);
        check("dual_valid", 64'(if2.cdb_valid), 64'h3);
        check("dual_tag",   64'(if2.cdb_tag),   64'h72);
        check("dual_data",  64'(if2.cdb_data),  {32'hBB, 32'hAA});
        idle(2);

        // Full FIFO: one bus cannot keep up with two sources pushing every cycle.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            drive(2'b11, TW'(k), DW'(32'hF000 + k), TW'(9 + (k % 7)), DW'(32'hE000 + k));
            tick();
        end
        idle(12);
        check("full_ready_dropped", 64'(ready0_low_seen), 64'd1);
        check("full_ovf_fu0",       64'(if1.overflow[0]), 64'd1);
        check("full_two_bus_no_ovf", 64'(if2.overflow),   64'd0);

        // Tag-0 push is discarded without a broadcast.
        do_reset();
        drive(2'b01, 4'd0, 32'h55, '0, '0);
        tick();
        idle(3);
        check("tag0_no_broadcast", 64'(valid_events), 64'd0);

        // Reset with three entries queued: nothing follows.
        do_reset();
        drive(2'b11, 4'd4, 32'h41, 4'd8, 32'h81);
        tick();
        drive(2'b11, 4'd4, 32'h42, 4'd8, 32'h82);
        tick();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        valid_events = 0;
        idle(5);
        check("midreset_flushed", 64'(valid_events), 64'd0);

        // Randomized traffic with occasional tag-0 pushes and resets.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            drive({logic'($urandom_range(0, 99) < 60), logic'($urandom_range(0, 99) < 60)},
                  TW'($urandom_range(0, 15)), DW'($urandom),
                  TW'($urandom_range(0, 15)), DW'($urandom));
            tick();
        end
        reset = 1'b0;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
